// File: rtl/rs_alu_scheduler_pkg.sv
// Shared types and constants for the ALU reservation station: opcode enum,
// data/tag types and the per-entry record.
package rs_alu_scheduler_pkg;

  localparam int RS_SIZE   = 16;
  localparam int RS_IDX_W  = 4;
  localparam int ROB_TAG_W = 4;
  localparam int OPENUM_W  = 6;
  localparam int DATA_W    = 32;

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [DATA_W-1:0]    addr_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef enum logic [OPENUM_W-1:0] {
    OPENUM_NOP  = 6'd0,
    OPENUM_ADD  = 6'd1,
    OPENUM_SUB  = 6'd2,
    OPENUM_ADDI = 6'd3,
    OPENUM_BEQ  = 6'd4
  } openum_t;

  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;
  localparam data_t ZERO_WORD = '0;

  typedef struct packed {
    logic     busy;
    openum_t  openum;
    data_t    v1;
    data_t    v2;
    rob_tag_t q1;
    rob_tag_t q2;
    logic     q1_busy;
    logic     q2_busy;
    data_t    imm;
    addr_t    pc;
    rob_tag_t rob_tag;
  } rs_entry_t;

  function automatic logic cdb_hit(logic valid, rob_tag_t cdb_tag, rob_tag_t q_tag);
    return valid && (cdb_tag == q_tag);
  endfunction

endpackage

// File: rtl/rs_alu_scheduler_if.sv
// Bus bundle around the station: dispatch in, LSB CDB snoop, ALU request/reply
// and the registered ALU CDB broadcast out.
interface rs_alu_scheduler_if;
  import rs_alu_scheduler_pkg::*;

  logic     disp_valid;
  openum_t  disp_openum;
  data_t    disp_v1, disp_v2;
  rob_tag_t disp_q1, disp_q2;
  logic     disp_q1_busy, disp_q2_busy;
  data_t    disp_imm;
  addr_t    disp_pc;
  rob_tag_t disp_rob_tag;
  logic     rs_full;

  logic     lsb_cdb_valid;
  rob_tag_t lsb_cdb_tag;
  data_t    lsb_cdb_value;

  openum_t  alu_openum;
  data_t    alu_v1, alu_v2, alu_imm;
  addr_t    alu_pc;
  data_t    alu_result;
  addr_t    alu_target_pc;
  logic     alu_jump, alu_valid;

  logic     out_valid;
  rob_tag_t out_rob_tag;
  data_t    out_result;
  addr_t    out_target_pc;
  logic     out_jump;

  modport master (
    output disp_valid, disp_openum, disp_v1, disp_v2, disp_q1, disp_q2,
           disp_q1_busy, disp_q2_busy, disp_imm, disp_pc, disp_rob_tag,
           lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value,
           alu_result, alu_target_pc, alu_jump, alu_valid,
    input  rs_full, alu_openum, alu_v1, alu_v2, alu_imm, alu_pc,
           out_valid, out_rob_tag, out_result, out_target_pc, out_jump
  );

  modport slave (
    input  disp_valid, disp_openum, disp_v1, disp_v2, disp_q1, disp_q2,
           disp_q1_busy, disp_q2_busy, disp_imm, disp_pc, disp_rob_tag,
           lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value,
           alu_result, alu_target_pc, alu_jump, alu_valid,
    output rs_full, alu_openum, alu_v1, alu_v2, alu_imm, alu_pc,
           out_valid, out_rob_tag, out_result, out_target_pc, out_jump
  );
endinterface

// File: rtl/rs_alu_scheduler_prio_enc.sv
// Lowest-set-bit priority encoder; used for both the free-slot and the
// ready-to-issue pick.
module rs_prio_enc
  import rs_alu_scheduler_pkg::*;
#(
  parameter int N = RS_SIZE,
  parameter int W = RS_IDX_W
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan high to low so the lowest requesting index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu_scheduler.sv
// ALU reservation station: holds dispatched ops, snoops both CDBs for operand
// wakeup, issues one ready op per cycle and registers the ALU reply as a CDB pulse.
module rs_alu_scheduler
  import rs_alu_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clr,
  rs_alu_scheduler_if.slave bus
);

  rs_entry_t           ent [RS_SIZE];
  rs_entry_t           new_ent;
  logic [RS_SIZE-1:0]  free_req, ready_req;
  logic [RS_IDX_W-1:0] free_idx, sel_idx;
  logic                free_found, sel_found, issue;

  logic     out_valid_q, out_jump_q;
  rob_tag_t out_tag_q;
  data_t    out_result_q;
  addr_t    out_tpc_q;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_req[i]  = ~ent[i].busy;
      ready_req[i] = ent[i].busy & ~ent[i].q1_busy & ~ent[i].q2_busy;
    end
  end

  rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_enc (
    .req(free_req), .idx(free_idx), .found(free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_sel_enc (
    .req(ready_req), .idx(sel_idx), .found(sel_found)
  );

  assign bus.rs_full = ~free_found;
  assign issue       = sel_found & bus.alu_valid;

  always_comb begin
    bus.alu_openum = OPENUM_NOP;
    bus.alu_v1     = ZERO_WORD;
    bus.alu_v2     = ZERO_WORD;
    bus.alu_imm    = ZERO_WORD;
    bus.alu_pc     = ZERO_WORD;
    if (sel_found) begin
      bus.alu_openum = ent[sel_idx].openum;
      bus.alu_v1     = ent[sel_idx].v1;
      bus.alu_v2     = ent[sel_idx].v2;
      bus.alu_imm    = ent[sel_idx].imm;
      bus.alu_pc     = ent[sel_idx].pc;
    end
  end

  // Same-cycle CDB bypass so an operand broadcast during dispatch is not lost.
  always_comb begin
    new_ent         = '0;
    new_ent.busy    = 1'b1;
    new_ent.openum  = bus.disp_openum;
    new_ent.v1      = bus.disp_v1;
    new_ent.v2      = bus.disp_v2;
    new_ent.q1      = bus.disp_q1;
    new_ent.q2      = bus.disp_q2;
    new_ent.q1_busy = bus.disp_q1_busy;
    new_ent.q2_busy = bus.disp_q2_busy;
    new_ent.imm     = bus.disp_imm;
    new_ent.pc      = bus.disp_pc;
    new_ent.rob_tag = bus.disp_rob_tag;
    if (bus.disp_q1_busy) begin
      if (cdb_hit(out_valid_q, out_tag_q, bus.disp_q1)) begin
        new_ent.v1 = out_result_q;  new_ent.q1_busy = 1'b0;
      end else if (cdb_hit(bus.lsb_cdb_valid, bus.lsb_cdb_tag, bus.disp_q1)) begin
        new_ent.v1 = bus.lsb_cdb_value;  new_ent.q1_busy = 1'b0;
      end
    end
    if (bus.disp_q2_busy) begin
      if (cdb_hit(out_valid_q, out_tag_q, bus.disp_q2)) begin
        new_ent.v2 = out_result_q;  new_ent.q2_busy = 1'b0;
      end else if (cdb_hit(bus.lsb_cdb_valid, bus.lsb_cdb_tag, bus.disp_q2)) begin
        new_ent.v2 = bus.lsb_cdb_value;  new_ent.q2_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      out_valid_q  <= FALSE;
      out_jump_q   <= FALSE;
      out_tag_q    <= '0;
      out_result_q <= ZERO_WORD;
      out_tpc_q    <= ZERO_WORD;
    end else if (rdy) begin
      if (clr) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
        out_valid_q <= FALSE;
      end else begin
        // Wakeup: own registered broadcast takes priority over the LSB bus.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent[i].busy && ent[i].q1_busy) begin
            if (cdb_hit(out_valid_q, out_tag_q, ent[i].q1)) begin
              ent[i].v1 <= out_result_q;  ent[i].q1_busy <= 1'b0;
            end else if (cdb_hit(bus.lsb_cdb_valid, bus.lsb_cdb_tag, ent[i].q1)) begin
              ent[i].v1 <= bus.lsb_cdb_value;  ent[i].q1_busy <= 1'b0;
            end
          end
          if (ent[i].busy && ent[i].q2_busy) begin
            if (cdb_hit(out_valid_q, out_tag_q, ent[i].q2)) begin
              ent[i].v2 <= out_result_q;  ent[i].q2_busy <= 1'b0;
            end else if (cdb_hit(bus.lsb_cdb_valid, bus.lsb_cdb_tag, ent[i].q2)) begin
              ent[i].v2 <= bus.lsb_cdb_value;  ent[i].q2_busy <= 1'b0;
            end
          end
        end
        out_valid_q <= issue;
        if (issue) begin
          out_tag_q          <= ent[sel_idx].rob_tag;
          out_result_q       <= bus.alu_result;
          out_tpc_q          <= bus.alu_target_pc;
          out_jump_q         <= bus.alu_jump;
          ent[sel_idx].busy  <= 1'b0;
        end
        if (bus.disp_valid && free_found) ent[free_idx] <= new_ent;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_rob_tag   = out_tag_q;
  assign bus.out_result    = out_result_q;
  assign bus.out_target_pc = out_tpc_q;
  assign bus.out_jump      = out_jump_q;

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Bench for rs_alu_scheduler: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_rs_alu_scheduler;
  import rs_alu_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, clr, alu_stall;
  always #5 clk = ~clk;

  rs_alu_scheduler_if bus ();
  rs_alu_scheduler dut (.clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(bus));

  function automatic data_t alu_res(openum_t op, data_t a, data_t b, data_t imm);
    case (op)
      OPENUM_ADD:  return a + b;
      OPENUM_SUB:  return a - b;
      OPENUM_ADDI: return a + imm;
      default:     return '0;
    endcase
  endfunction

  function automatic logic alu_jmp(openum_t op, data_t a, data_t b);
    return (op == OPENUM_BEQ) && (a == b);
  endfunction

  function automatic data_t alu_tgt(openum_t op, data_t pc, data_t imm);
    return (op == OPENUM_BEQ) ? pc + imm : pc + 32'd4;
  endfunction

  // Combinational ALU stand-in; alu_stall lets the bench withhold alu_valid.
  always_comb begin
    bus.alu_valid     = (bus.alu_openum != OPENUM_NOP) && !alu_stall;
    bus.alu_result    = alu_res(bus.alu_openum, bus.alu_v1, bus.alu_v2, bus.alu_imm);
    bus.alu_jump      = alu_jmp(bus.alu_openum, bus.alu_v1, bus.alu_v2);
    bus.alu_target_pc = alu_tgt(bus.alu_openum, bus.alu_pc, bus.alu_imm);
  end

  bit       m_busy [RS_SIZE];
  bit       m_qb1 [RS_SIZE], m_qb2 [RS_SIZE];
  openum_t  m_op [RS_SIZE];
  data_t    m_v1 [RS_SIZE], m_v2 [RS_SIZE], m_imm [RS_SIZE], m_pc [RS_SIZE];
  rob_tag_t m_q1 [RS_SIZE], m_q2 [RS_SIZE], m_tag [RS_SIZE];
  bit       m_ov, m_ojmp;
  rob_tag_t m_otag;
  data_t    m_ores, m_otpc;

  bit       s_rst, s_rdy, s_clr, s_dv, s_qb1, s_qb2, s_lv, s_stall;
  openum_t  s_op;
  data_t    s_v1, s_v2, s_imm, s_pc, s_lval;
  rob_tag_t s_q1, s_q2, s_tag, s_lt;

  int n_cmp, n_bad;

  function automatic int m_sel();
    for (int i = 0; i < RS_SIZE; i++)
      if (m_busy[i] && !m_qb1[i] && !m_qb2[i]) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < RS_SIZE; i++)
      if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge from its current state and the driven inputs.
  task automatic modelStep();
    automatic int  sel = m_sel();
    automatic int  fr  = m_free();
    automatic bit  o_v = m_ov;
    automatic rob_tag_t o_t = m_otag;
    automatic data_t    o_r = m_ores;
    if (s_rst) begin
      for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 0;
      m_ov = 0; m_otag = '0; m_ores = '0; m_otpc = '0; m_ojmp = 0;
    end else if (!s_rdy) begin
    end else if (s_clr) begin
      for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 0;
      m_ov = 0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (!m_busy[i]) continue;
        if (m_qb1[i]) begin
          if (o_v && o_t == m_q1[i]) begin m_v1[i] = o_r; m_qb1[i] = 0; end
          else if (s_lv && s_lt == m_q1[i]) begin m_v1[i] = s_lval; m_qb1[i] = 0; end
        end
        if (m_qb2[i]) begin
          if (o_v && o_t == m_q2[i]) begin m_v2[i] = o_r; m_qb2[i] = 0; end
          else if (s_lv && s_lt == m_q2[i]) begin m_v2[i] = s_lval; m_qb2[i] = 0; end
        end
      end
      if (sel >= 0 && !s_stall) begin
        m_ov   = 1;
        m_otag = m_tag[sel];
        m_ores = alu_res(m_op[sel], m_v1[sel], m_v2[sel], m_imm[sel]);
        m_otpc = alu_tgt(m_op[sel], m_pc[sel], m_imm[sel]);
        m_ojmp = alu_jmp(m_op[sel], m_v1[sel], m_v2[sel]);
        m_busy[sel] = 0;
      end else begin
        m_ov = 0;
      end
      if (s_dv && fr >= 0) begin
        m_busy[fr] = 1; m_op[fr] = s_op; m_imm[fr] = s_imm; m_pc[fr] = s_pc;
        m_tag[fr] = s_tag; m_q1[fr] = s_q1; m_q2[fr] = s_q2;
        m_v1[fr] = s_v1; m_qb1[fr] = s_qb1; m_v2[fr] = s_v2; m_qb2[fr] = s_qb2;
        if (s_qb1 && o_v && o_t == s_q1) begin m_v1[fr] = o_r; m_qb1[fr] = 0; end
        else if (s_qb1 && s_lv && s_lt == s_q1) begin m_v1[fr] = s_lval; m_qb1[fr] = 0; end
        if (s_qb2 && o_v && o_t == s_q2) begin m_v2[fr] = o_r; m_qb2[fr] = 0; end
        else if (s_qb2 && s_lv && s_lt == s_q2) begin m_v2[fr] = s_lval; m_qb2[fr] = 0; end
      end
    end
  endtask

  task automatic applyStimulus();
    rst = s_rst; rdy = s_rdy; clr = s_clr; alu_stall = s_stall;
    bus.disp_valid   = s_dv;   bus.disp_openum  = s_op;
    bus.disp_v1      = s_v1;   bus.disp_v2      = s_v2;
    bus.disp_q1      = s_q1;   bus.disp_q2      = s_q2;
    bus.disp_q1_busy = s_qb1;  bus.disp_q2_busy = s_qb2;
    bus.disp_imm     = s_imm;  bus.disp_pc      = s_pc;
    bus.disp_rob_tag = s_tag;
    bus.lsb_cdb_valid = s_lv;  bus.lsb_cdb_tag = s_lt;  bus.lsb_cdb_value = s_lval;
    #1;
    if (s_dv && bus.rs_full && s_rdy && !s_rst)
      $display("[TB] note: dispatch while rs_full is a protocol violation, expected to be dropped");
  endtask

  // Model-driven comparison of every DUT output, run once per cycle.
  task automatic checkOutput();
    automatic int sel = m_sel();
    chk("rs_full", 32'(bus.rs_full), 32'(m_free() < 0));
    if (sel >= 0) begin
      chk("alu_openum", 32'(bus.alu_openum), 32'(m_op[sel]));
      chk("alu_v1", bus.alu_v1, m_v1[sel]);
      chk("alu_v2", bus.alu_v2, m_v2[sel]);
      chk("alu_imm", bus.alu_imm, m_imm[sel]);
      chk("alu_pc", bus.alu_pc, m_pc[sel]);
    end else begin
      chk("alu_openum_idle", 32'(bus.alu_openum), 32'(OPENUM_NOP));
      chk("alu_v1_idle", bus.alu_v1, 32'd0);
    end
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_rob_tag", 32'(bus.out_rob_tag), 32'(m_otag));
      chk("out_result", bus.out_result, m_ores);
      chk("out_target_pc", bus.out_target_pc, m_otpc);
      chk("out_jump", 32'(bus.out_jump), 32'(m_ojmp));
    end
  endtask

  task automatic cycle();
    applyStimulus();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle();
    s_rst = 0; s_rdy = 1; s_clr = 0; s_dv = 0; s_stall = 0; s_lv = 0;
    s_op = OPENUM_ADD; s_v1 = '0; s_v2 = '0; s_imm = '0; s_pc = '0;
    s_q1 = '0; s_q2 = '0; s_qb1 = 0; s_qb2 = 0; s_tag = '0; s_lt = '0; s_lval = '0;
  endtask

  task automatic setDisp(input openum_t op, input data_t v1, input data_t v2,
                         input bit qb1, input rob_tag_t q1, input bit qb2, input rob_tag_t q2,
                         input data_t imm, input data_t pc, input rob_tag_t tag);
    s_dv = 1; s_op = op; s_v1 = v1; s_v2 = v2; s_qb1 = qb1; s_q1 = q1;
    s_qb2 = qb2; s_q2 = q2; s_imm = imm; s_pc = pc; s_tag = tag;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    idle(); s_rst = 1; cycle(); idle(); cycle();
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_rs_full", 32'(bus.rs_full), 32'd0);
    chk("reset_out_result", bus.out_result, 32'd0);
    chk("reset_alu_openum", 32'(bus.alu_openum), 32'(OPENUM_NOP));

    // Ready ADD: ALU request the cycle after dispatch, broadcast one edge later.
    setDisp(OPENUM_ADD, 5, 7, 0, 0, 0, 0, 0, 0, 3); cycle(); idle();
    chk("t1_alu_openum", 32'(bus.alu_openum), 32'(OPENUM_ADD));
    cycle();
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_out_rob_tag", 32'(bus.out_rob_tag), 32'd3);
    chk("t1_out_result", bus.out_result, 32'd12);
    cycle();
    chk("t1_pulse_end", 32'(bus.out_valid), 32'd0);

    // ADDI waiting on LSB tag 6.
    setDisp(OPENUM_ADDI, 0, 0, 1, 6, 0, 0, 1, 0, 4); cycle(); idle();
    chk("t2_wait0", 32'(bus.alu_openum), 32'(OPENUM_NOP));
    cycle();
    chk("t2_wait1", 32'(bus.alu_openum), 32'(OPENUM_NOP));
    s_lv = 1; s_lt = 6; s_lval = 32'h10; cycle(); idle();
    chk("t2_woken_op", 32'(bus.alu_openum), 32'(OPENUM_ADDI));
    chk("t2_woken_v1", bus.alu_v1, 32'h10);
    cycle();
    chk("t2_out_result", bus.out_result, 32'h11);

    // Same-cycle bypass of operand 2 from the LSB bus.
    setDisp(OPENUM_SUB, 20, 0, 0, 0, 1, 2, 0, 0, 5);
    s_lv = 1; s_lt = 2; s_lval = 9; cycle(); idle();
    chk("t3_alu_v2", bus.alu_v2, 32'd9);
    cycle();
    chk("t3_out_result", bus.out_result, 32'd11);

    // Fill all entries; only entry 0 waits on tag 8.
    for (int i = 0; i < RS_SIZE; i++) begin
      setDisp(OPENUM_ADD, 0, data_t'(i), 1, (i == 0) ? 4'd8 : 4'd9, 0, 0, 0, 0, rob_tag_t'(i));
      cycle();
    end
    chk("t4_full", 32'(bus.rs_full), 32'd1);
    setDisp(OPENUM_ADD, 1, 1, 0, 0, 0, 0, 0, 0, 15); cycle(); idle();
    chk("t4_full_after_17th", 32'(bus.rs_full), 32'd1);
    s_lv = 1; s_lt = 8; s_lval = 1; cycle(); idle();
    chk("t4_wake_v1", bus.alu_v1, 32'd1);
    chk("t4_still_full", 32'(bus.rs_full), 32'd1);
    cycle();
    chk("t4_not_full", 32'(bus.rs_full), 32'd0);
    chk("t4_out_tag", 32'(bus.out_rob_tag), 32'd0);
    s_lv = 1; s_lt = 9; s_lval = 2; cycle(); idle();
    for (int i = 0; i < 18; i++) cycle();

    // Taken branch, then flush with entries pending and a dispatch in the flush cycle.
    setDisp(OPENUM_BEQ, 4, 4, 0, 0, 0, 0, 8, 32'h100, 1); cycle(); idle(); cycle();
    chk("t5_jump", 32'(bus.out_jump), 32'd1);
    chk("t5_target", bus.out_target_pc, 32'h108);
    for (int i = 0; i < 3; i++) begin
      setDisp(OPENUM_ADD, 0, 0, 1, 12, 0, 0, 0, 0, rob_tag_t'(i + 4)); cycle();
    end
    setDisp(OPENUM_ADD, 1, 1, 0, 0, 0, 0, 0, 0, 2); cycle();
    setDisp(OPENUM_SUB, 3, 1, 0, 0, 0, 0, 0, 0, 3); s_clr = 1; cycle(); idle();
    chk("t5_clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_clr_alu_idle", 32'(bus.alu_openum), 32'(OPENUM_NOP));
    chk("t5_clr_rs_full", 32'(bus.rs_full), 32'd0);
    s_lv = 1; s_lt = 12; s_lval = 5; cycle(); idle(); cycle();
    chk("t5_flushed_stay_gone", 32'(bus.alu_openum), 32'(OPENUM_NOP));

    // Freeze with rdy=0, then reset with entries busy.
    setDisp(OPENUM_ADD, 1, 2, 0, 0, 0, 0, 0, 0, 10); cycle();
    setDisp(OPENUM_SUB, 9, 4, 0, 0, 0, 0, 0, 0, 11); cycle();
    setDisp(OPENUM_ADDI, 1, 0, 0, 0, 0, 0, 3, 0, 12); s_rdy = 0; s_lv = 1; s_lt = 0; s_lval = 7;
    for (int i = 0; i < 3; i++) cycle();
    idle();
    chk("t6_held_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_held_tag", 32'(bus.out_rob_tag), 32'd10);
    chk("t6_held_result", bus.out_result, 32'd3);
    chk("t6_held_alu", 32'(bus.alu_openum), 32'(OPENUM_SUB));
    setDisp(OPENUM_ADD, 0, 0, 1, 14, 0, 0, 0, 0, 13); cycle(); idle();
    s_rst = 1; cycle(); idle();
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_tag", 32'(bus.out_rob_tag), 32'd0);
    chk("t6_rst_result", bus.out_result, 32'd0);
    chk("t6_rst_target", bus.out_target_pc, 32'd0);
    chk("t6_rst_full", 32'(bus.rs_full), 32'd0);
    chk("t6_rst_alu", 32'(bus.alu_openum), 32'(OPENUM_NOP));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      s_rdy   = ($urandom_range(0, 9) != 0);
      s_clr   = ($urandom_range(0, 49) == 0);
      s_rst   = ($urandom_range(0, 199) == 0);
      s_stall = ($urandom_range(0, 4) == 0);
      s_dv    = ($urandom_range(0, 1) == 1) && (m_free() >= 0);
      case ($urandom_range(0, 3))
        0: s_op = OPENUM_ADD;
        1: s_op = OPENUM_SUB;
        2: s_op = OPENUM_ADDI;
        default: s_op = OPENUM_BEQ;
      endcase
      s_v1  = $urandom_range(0, 7);  s_v2 = $urandom_range(0, 7);
      s_imm = $urandom();            s_pc = $urandom();
      s_qb1 = ($urandom_range(0, 9) < 4); s_q1 = rob_tag_t'($urandom());
      s_qb2 = ($urandom_range(0, 9) < 4); s_q2 = rob_tag_t'($urandom());
      s_tag = rob_tag_t'($urandom());
      s_lv  = ($urandom_range(0, 9) < 3); s_lt = rob_tag_t'($urandom()); s_lval = $urandom();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
